mem_fill_responder: RTL and testbench

- Memory-side responder for the cache fill protocol: accepts one word request per cycle and returns read data with a fixed multi-cycle latency on memory_data / memory_data_valid.
- Sits between the cache fill controllers (I- and D-cache) and the backing word store. Acts as the unified main memory in the Phase 3 system.
- Fully pipelined: up to LATENCY reads in flight, no stall, no back-pressure.

---
 rtl/mem_fill_responder_pkg.sv | 17 +
 rtl/mem_fill_responder_if.sv | 27 ++
 rtl/mem_fill_responder_delay_pipe.sv | 54 +++++
 rtl/mem_fill_responder.sv | 100 ++++++++++
 tb/tb_mem_fill_responder.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_fill_responder_pkg.sv
// Shared types and constants for the unified fill-protocol memory responder.
// Imported by the interface, the delay pipe and the top level.
package mem_fill_pkg;

   typedef logic [15:0] word_t;

   localparam int DEFAULT_LATENCY = 4;
   localparam int WORD_BYTES      = 2;

   // An address is illegal when it is not word aligned or selects a word beyond the array.
   function automatic logic addr_is_bad(input logic [15:0] addr, input int addr_w);
      logic [15:0] high_s;
      high_s = addr >> (addr_w + 1);
      return addr[0] | (high_s != 16'h0000);
   endfunction

endpackage

// File: rtl/mem_fill_responder_if.sv
// Request/response bundle between the cache fill controllers (master) and the memory responder (slave).
// The err signal exists only when MEM_FILL_RESPONDER_ERR_EN is defined.
interface mem_fill_responder_if;
   import mem_fill_pkg::*;

   logic        enable;
   logic        wr;
   logic [15:0] address;
   word_t       data_in;
   word_t       memory_data;
   logic        memory_data_valid;
   logic [3:0]  pending;
`ifdef MEM_FILL_RESPONDER_ERR_EN
   logic        err;

   modport master (output enable, wr, address, data_in,
                   input  memory_data, memory_data_valid, pending, err);
   modport slave  (input  enable, wr, address, data_in,
                   output memory_data, memory_data_valid, pending, err);
`else
   modport master (output enable, wr, address, data_in,
                   input  memory_data, memory_data_valid, pending);
   modport slave  (input  enable, wr, address, data_in,
                   output memory_data, memory_data_valid, pending);
`endif

endinterface

// File: rtl/mem_fill_responder_delay_pipe.sv
// LATENCY-stage shift register of {valid, word}; reset clears the valid bits only.
// A data stage loads only when a valid word enters it, so the last stage holds the last returned word.
module resp_delay_pipe
   import mem_fill_pkg::*;
#(
   parameter int LATENCY = DEFAULT_LATENCY
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  in_valid,
   input  word_t in_data,
   output logic  out_valid,
   output word_t out_data,
   output logic  last_load
);

   logic [LATENCY-1:0] vld_r;
   logic [LATENCY-1:0] load_s;
   word_t              dat_r    [LATENCY];
   word_t              dat_in_s [LATENCY];

   // load_s[i] is the valid bit entering stage i at the coming edge
   assign load_s    = (vld_r << 1) | LATENCY'(in_valid);
   assign last_load = load_s[LATENCY-1];
   assign out_valid = vld_r[LATENCY-1];
   assign out_data  = dat_r[LATENCY-1];

   // Data presented to each stage: the request word for stage 0, the previous stage otherwise.
   always_comb begin
      dat_in_s[0] = in_data;
      for (int i = 1; i < LATENCY; i++) begin
         dat_in_s[i] = dat_r[i-1];
      end
   end

   // Valid shift register with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_r <= '0;
      end else begin
         vld_r <= load_s;
      end
   end

   // Data stages advance only with a valid word and are never reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < LATENCY; i++) begin
         if (load_s[i]) begin
            dat_r[i] <= dat_in_s[i];
         end
      end
   end

endmodule

// File: rtl/mem_fill_responder.sv
// Unified main memory for the fill protocol: one request per cycle, reads return after LATENCY cycles.
// Define MEM_FILL_RESPONDER_ERR_EN to add the err output and suppress writes to illegal addresses.
module mem_fill_responder
   import mem_fill_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = DEFAULT_LATENCY
) (
   input logic                 clk,
   input logic                 rst_n,
   mem_fill_responder_if.slave bus
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [ADDR_W-1:0] idx_s;
   logic              bad_s;
   logic              rd_acc_s;
   logic              wr_acc_s;
   word_t             rd_word_s;
   word_t             pipe_data_s;
   logic              pipe_valid_s;
   logic              last_load_s;
   logic              returned_r;
   logic [3:0]        pending_r;
   word_t             mem_r [DEPTH];

   assign idx_s = bus.address[ADDR_W:1];

`ifdef MEM_FILL_RESPONDER_ERR_EN
   assign bad_s = addr_is_bad(bus.address, ADDR_W);
`else
   // Byte-select and high address bits alias silently in this build.
   logic unused_addr_s;
   assign bad_s         = 1'b0;
   assign unused_addr_s = ^{bus.address[15:ADDR_W+1], bus.address[0]};
`endif

   assign rd_acc_s  = rst_n & bus.enable & ~bus.wr;
   assign wr_acc_s  = rst_n & bus.enable & bus.wr & ~bad_s;
   assign rd_word_s = mem_r[idx_s];

   // Word store; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_acc_s) begin
         mem_r[idx_s] <= bus.data_in;
      end
   end

   resp_delay_pipe #(.LATENCY(LATENCY)) u_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (rd_acc_s),
      .in_data   (rd_word_s),
      .out_valid (pipe_valid_s),
      .out_data  (pipe_data_s),
      .last_load (last_load_s)
   );

   // In-flight read count and a flag that unmasks the returned word once a read has come back since reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending_r  <= 4'd0;
         returned_r <= 1'b0;
      end else begin
         case ({rd_acc_s, last_load_s})
            2'b10:   pending_r <= pending_r + 4'd1;
            2'b01:   pending_r <= pending_r - 4'd1;
            default: pending_r <= pending_r;
         endcase
         if (last_load_s) begin
            returned_r <= 1'b1;
         end
      end
   end

   assign bus.memory_data_valid = pipe_valid_s;
   assign bus.memory_data       = returned_r ? pipe_data_s : 16'h0000;
   assign bus.pending           = pending_r;

`ifdef MEM_FILL_RESPONDER_ERR_EN
   logic [LATENCY-1:0] err_pipe_r;
   logic               wr_bad_s;

   assign wr_bad_s = bus.enable & bus.wr & bad_s;

   // Read errors travel alongside their data; write errors enter the last stage directly.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_pipe_r <= '0;
      end else begin
         err_pipe_r <= (err_pipe_r << 1) | LATENCY'(rd_acc_s & bad_s)
                       | (LATENCY'(wr_bad_s) << (LATENCY - 1));
      end
   end

   assign bus.err = err_pipe_r[LATENCY-1];
`endif

endmodule

// File: tb/tb_mem_fill_responder.sv
// Self-checking bench for mem_fill_responder: directed scenarios plus random traffic against a queue-based model.
module tb_mem_fill_responder;
   import mem_fill_pkg::*;

   localparam int ADDR_W = 10;
   localparam int LAT    = DEFAULT_LATENCY;
`ifdef MEM_FILL_RESPONDER_ERR_EN
   localparam bit ERR_MODE = 1'b1;
`else
   localparam bit ERR_MODE = 1'b0;
`endif

   typedef struct {
      int          due;
      logic [15:0] data;
      bit          err;
   } ent_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_fill_responder_if bus ();

   mem_fill_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   ent_t        q[$];
   logic [15:0] mem_m [1 << ADDR_W];
   int          cyc = 0;
   logic        exp_valid = 1'b0;
   logic [15:0] exp_data  = 16'h0000;
   int          exp_pend  = 0;
   logic        exp_err   = 1'b0;
   int          checks    = 0;
   int          failures  = 0;

   function automatic bit bad_addr(input logic [15:0] a);
      return (a[0] == 1'b1) || ((a >> (ADDR_W + 1)) != 16'h0000);
   endfunction

   function automatic int widx(input logic [15:0] a);
      return int'(a >> 1) % (1 << ADDR_W);
   endfunction

   task automatic drive(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
      bus.enable  = en;
      bus.wr      = w;
      bus.address = a;
      bus.data_in = d;
   endtask

   // Advance one edge and update the reference model; returns #1 after the edge.
   task automatic tick();
      ent_t e;
      logic wr_bad;
      @(posedge clk);
      wr_bad = 1'b0;
      if (!rst_n) begin
         q.delete();
         exp_data = 16'h0000;
      end else if (bus.enable) begin
         if (bus.wr) begin
            if (ERR_MODE && bad_addr(bus.address)) wr_bad = 1'b1;
            else mem_m[widx(bus.address)] = bus.data_in;
         end else begin
            e.due  = cyc + LAT;
            e.data = mem_m[widx(bus.address)];
            e.err  = ERR_MODE && bad_addr(bus.address);
            q.push_back(e);
         end
      end
      cyc++;
      exp_valid = 1'b0;
      exp_err   = wr_bad;
      if (q.size() > 0 && q[0].due == cyc) begin
         e         = q.pop_front();
         exp_valid = 1'b1;
         exp_data  = e.data;
         exp_err   = exp_err | e.err;
      end
      exp_pend = q.size();
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      tick();
      tick();
      checks++;
      if (bus.memory_data_valid !== 1'b0) begin
         failures++; $display("FAIL reset_valid got=%b exp=0", bus.memory_data_valid);
      end
      checks++;
      if (bus.memory_data !== 16'h0000) begin
         failures++; $display("FAIL reset_data got=%h exp=0000", bus.memory_data);
      end
      checks++;
      if (bus.pending !== 4'd0) begin
         failures++; $display("FAIL reset_pending got=%0d exp=0", bus.pending);
      end
`ifdef MEM_FILL_RESPONDER_ERR_EN
      checks++;
      if (bus.err !== 1'b0) begin
         failures++; $display("FAIL reset_err got=%b exp=0", bus.err);
      end
`endif
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      int seen = 0;
      for (int k = 0; k < 8; k++) begin
         if (k == 0) drive(1'b1, 1'b1, 16'h0120, 16'hBEEF);
         else if (k == 2) drive(1'b1, 1'b0, 16'h0120, 16'h0000);
         else drive(1'b0, 1'b0, 16'h0000, 16'h0000);
         tick();
         checks++;
         if (bus.memory_data_valid !== exp_valid || bus.memory_data !== exp_data || bus.pending !== 4'(exp_pend)) begin
            failures++;
            $display("FAIL single cyc=%0d valid=%b exp %b data=%h exp %h pending=%0d exp %0d",
                     cyc, bus.memory_data_valid, exp_valid, bus.memory_data, exp_data, bus.pending, exp_pend);
         end
         if (exp_valid) begin
            seen++;
            checks++;
            if (bus.memory_data !== 16'hBEEF) begin
               failures++; $display("FAIL single_beef got=%h exp=beef", bus.memory_data);
            end
         end
      end
      checks++;
      if (seen != 1) begin
         failures++; $display("FAIL single_count got=%0d exp=1", seen);
      end
   endtask

   task automatic test_burst();
      int nvalid = 0;
      int peak   = 0;
      for (int k = 0; k < 8 + 8 + 6; k++) begin
         if (k < 8) drive(1'b1, 1'b1, 16'(16'h0120 + 2 * k), 16'(16'h1000 + k));
         else if (k < 16) drive(1'b1, 1'b0, 16'(16'h0120 + 2 * (k - 8)), 16'h0000);
         else drive(1'b0, 1'b0, 16'h0000, 16'h0000);
         tick();
         checks++;
         if (bus.memory_data_valid !== exp_valid || bus.memory_data !== exp_data || bus.pending !== 4'(exp_pend)) begin
            failures++;
            $display("FAIL burst cyc=%0d valid=%b exp %b data=%h exp %h pending=%0d exp %0d",
                     cyc, bus.memory_data_valid, exp_valid, bus.memory_data, exp_data, bus.pending, exp_pend);
         end
         if (bus.memory_data_valid === 1'b1) nvalid++;
         if (int'(bus.pending) > peak) peak = int'(bus.pending);
      end
      checks++;
      if (nvalid != 8) begin
         failures++; $display("FAIL burst_count got=%0d exp=8", nvalid);
      end
      checks++;
      if (peak > LAT || peak == 0) begin
         failures++; $display("FAIL burst_peak got=%0d exp=1..%0d", peak, LAT);
      end
   endtask

   task automatic test_capture();
      for (int k = 0; k < 14; k++) begin
         case (k)
            0:       drive(1'b1, 1'b1, 16'h0040, 16'h1111);
            1:       drive(1'b1, 1'b0, 16'h0040, 16'h0000);
            2:       drive(1'b1, 1'b1, 16'h0040, 16'h2222);
            6:       drive(1'b1, 1'b0, 16'h0040, 16'h0000);
            default: drive(1'b0, 1'b0, 16'h0000, 16'h0000);
         endcase
         tick();
         checks++;
         if (bus.memory_data_valid !== exp_valid || bus.memory_data !== exp_data || bus.pending !== 4'(exp_pend)) begin
            failures++;
            $display("FAIL capture cyc=%0d valid=%b exp %b data=%h exp %h pending=%0d exp %0d",
                     cyc, bus.memory_data_valid, exp_valid, bus.memory_data, exp_data, bus.pending, exp_pend);
         end
      end
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 14; k++) begin
         rst_n = (k == 2) ? 1'b0 : 1'b1;
         if (k < 3) drive(1'b1, 1'b0, 16'(16'h0120 + 2 * k), 16'h0000);
         else if (k == 7) drive(1'b1, 1'b0, 16'h0120, 16'h0000);
         else drive(1'b0, 1'b0, 16'h0000, 16'h0000);
         tick();
         checks++;
         if (bus.memory_data_valid !== exp_valid || bus.memory_data !== exp_data || bus.pending !== 4'(exp_pend)) begin
            failures++;
            $display("FAIL reset_mid cyc=%0d valid=%b exp %b data=%h exp %h pending=%0d exp %0d",
                     cyc, bus.memory_data_valid, exp_valid, bus.memory_data, exp_data, bus.pending, exp_pend);
         end
      end
      rst_n = 1'b1;
   endtask

`ifndef MEM_FILL_RESPONDER_ERR_EN
   task automatic test_alias();
      for (int k = 0; k < 7; k++) begin
         if (k == 0) drive(1'b1, 1'b1, 16'h0801, 16'h00AA);
         else if (k == 1) drive(1'b1, 1'b0, 16'h0000, 16'h0000);
         else drive(1'b0, 1'b0, 16'h0000, 16'h0000);
         tick();
         checks++;
         if (bus.memory_data_valid !== exp_valid || bus.memory_data !== exp_data || bus.pending !== 4'(exp_pend)) begin
            failures++;
            $display("FAIL alias cyc=%0d valid=%b exp %b data=%h exp %h pending=%0d exp %0d",
                     cyc, bus.memory_data_valid, exp_valid, bus.memory_data, exp_data, bus.pending, exp_pend);
         end
         if (exp_valid) begin
            checks++;
            if (bus.memory_data !== 16'h00AA) begin
               failures++; $display("FAIL alias_data got=%h exp=00aa", bus.memory_data);
            end
         end
      end
   endtask
`else
   task automatic test_err();
      for (int k = 0; k < 14; k++) begin
         case (k)
            0:       drive(1'b1, 1'b1, 16'h0000, 16'h5555);
            1:       drive(1'b1, 1'b0, 16'h0121, 16'h0000);
            6:       drive(1'b1, 1'b1, 16'h0801, 16'h00AA);
            7:       drive(1'b1, 1'b0, 16'h0000, 16'h0000);
            default: drive(1'b0, 1'b0, 16'h0000, 16'h0000);
         endcase
         tick();
         checks++;
         if (bus.memory_data_valid !== exp_valid || bus.memory_data !== exp_data
             || bus.pending !== 4'(exp_pend) || bus.err !== exp_err) begin
            failures++;
            $display("FAIL err cyc=%0d valid=%b exp %b data=%h exp %h pending=%0d exp %0d err=%b exp %b",
                     cyc, bus.memory_data_valid, exp_valid, bus.memory_data, exp_data,
                     bus.pending, exp_pend, bus.err, exp_err);
         end
      end
   endtask
`endif

   task automatic test_random();
      logic [15:0] a;
      int          w;
      for (int k = 0; k < 32; k++) begin
         drive(1'b1, 1'b1, 16'(2 * k), 16'($urandom));
         tick();
      end
      for (int k = 0; k < 200; k++) begin
         w = int'($urandom_range(0, 31));
         a = 16'(2 * w);
         if (!ERR_MODE) a = a | 16'($urandom_range(0, 1)) | 16'(($urandom_range(0, 31)) << 11);
         case ($urandom_range(0, 2))
            0:       drive(1'b0, 1'b0, a, 16'($urandom));
            1:       drive(1'b1, 1'b1, a, 16'($urandom));
            default: drive(1'b1, 1'b0, a, 16'($urandom));
         endcase
         tick();
         checks++;
         if (bus.memory_data_valid !== exp_valid || bus.memory_data !== exp_data || bus.pending !== 4'(exp_pend)) begin
            failures++;
            $display("FAIL random cyc=%0d valid=%b exp %b data=%h exp %h pending=%0d exp %0d",
                     cyc, bus.memory_data_valid, exp_valid, bus.memory_data, exp_data, bus.pending, exp_pend);
         end
      end
   endtask

   initial begin
      drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      test_reset();
      test_single();
      test_burst();
      test_capture();
      test_reset_mid();
`ifndef MEM_FILL_RESPONDER_ERR_EN
      test_alias();
`else
      test_err();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
